// File: rtl/sad_pkg.sv
// Shared FSM states and sizing helpers for the SAD block controller.
// Optional best-match tracking is enabled with SAD_MIN_TRACK_EN.
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } sad_state_t;

  localparam int DRAIN_CYCLES = 2;

  function automatic int acc_width(
    input int data_w,
    input int block_len
  );
    return data_w + $clog2(block_len);
  endfunction

endpackage

// File: rtl/sad_block_controller_if.sv
// Pixel stream, control and result bundle of the SAD controller.
// best_sad/best_cand exist only when SAD_MIN_TRACK_EN is defined.
interface sad_block_controller_if #(
  parameter int DATA_W    = 8,
  parameter int BLOCK_LEN = 64,
  parameter int CAND_W    = 6
);
  import sad_pkg::*;

  localparam int ACC_W = acc_width(DATA_W, BLOCK_LEN);

  logic              start;
  logic              new_search;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sad;
  logic [CAND_W-1:0] out_cand;
  logic              busy;
`ifdef SAD_MIN_TRACK_EN
  logic [ACC_W-1:0]  best_sad;
  logic [CAND_W-1:0] best_cand;

  modport master (
    output start, new_search,
    output in_valid, in_a, in_b,
    output out_ready,
    input  in_ready, out_valid,
    input  out_sad, out_cand, busy,
    input  best_sad, best_cand
  );

  modport slave (
    input  start, new_search,
    input  in_valid, in_a, in_b,
    input  out_ready,
    output in_ready, out_valid,
    output out_sad, out_cand, busy,
    output best_sad, best_cand
  );
`else
  modport master (
    output start, new_search,
    output in_valid, in_a, in_b,
    output out_ready,
    input  in_ready, out_valid,
    input  out_sad, out_cand, busy
  );

  modport slave (
    input  start, new_search,
    input  in_valid, in_a, in_b,
    input  out_ready,
    output in_ready, out_valid,
    output out_sad, out_cand, busy
  );
`endif

endinterface

// File: rtl/sad_absdiff.sv
// Shared unsigned absolute-difference datapath.
// Purely combinational; the controller registers its result.
module sad_absdiff #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] d
);

  assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_block_controller.sv
// Sequences one SAD block: accept pairs, drain pipe, hold result.
// Best-match tracking is built when SAD_MIN_TRACK_EN is defined.
module sad_block_controller
  import sad_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BLOCK_LEN = 64,
  parameter int CAND_W    = 6
) (
  input logic                  clk,
  input logic                  rst,
  sad_block_controller_if.slave bus
);

  localparam int ACC_W  = acc_width(DATA_W, BLOCK_LEN);
  localparam int CNT_W  = $clog2(BLOCK_LEN);
  localparam int DCNT_W = $clog2(DRAIN_CYCLES);

  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(BLOCK_LEN - 1);
  localparam logic [DCNT_W-1:0] LAST_DRAIN =
    DCNT_W'(DRAIN_CYCLES - 1);

  sad_state_t        state;
  logic [CNT_W-1:0]  beat;
  logic [DCNT_W-1:0] dcnt;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] diff_q;
  logic              diff_vld;
  logic [ACC_W-1:0]  acc;
  logic [CAND_W-1:0] cand;
  logic              accept;

  sad_absdiff #(
    .DATA_W(DATA_W)
  ) u_absdiff (
    .a(bus.in_a),
    .b(bus.in_b),
    .d(diff)
  );

  assign accept      = bus.in_valid && (state == ACCUM);
  assign bus.in_ready = (state == ACCUM);
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= '0;
      dcnt          <= '0;
      diff_q        <= '0;
      diff_vld      <= 1'b0;
      acc           <= '0;
      cand          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sad   <= '0;
      bus.out_cand  <= '0;
    end else begin
      diff_vld <= accept;
      if (accept) diff_q <= diff;
      if (diff_vld) acc <= acc + ACC_W'(diff_q);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= ACCUM;
            beat  <= '0;
            acc   <= '0;
            if (bus.new_search) cand <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state <= DRAIN;
              dcnt  <= '0;
            end
          end
        end
        DRAIN: begin
          // last difference lands in acc one cycle before we leave
          dcnt <= dcnt + 1'b1;
          if (dcnt == LAST_DRAIN) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_sad   <= acc;
            bus.out_cand  <= cand;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            cand          <= cand + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAD_MIN_TRACK_EN
  logic out_hs;
  logic search_clr;

  assign out_hs     = bus.out_valid && bus.out_ready;
  assign search_clr = (state == IDLE) && bus.start &&
                      bus.new_search;

  // strict compare keeps the earliest candidate on ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.best_sad  <= '1;
      bus.best_cand <= '0;
    end else if (search_clr) begin
      bus.best_sad  <= '1;
      bus.best_cand <= '0;
    end else if (out_hs && (bus.out_sad < bus.best_sad)) begin
      bus.best_sad  <= bus.out_sad;
      bus.best_cand <= bus.out_cand;
    end
  end
`endif

endmodule

// File: tb/tb_sad_block_controller.sv
// Randomised scoreboard bench for sad_block_controller (BLOCK_LEN=4).
// Define SAD_MIN_TRACK_EN to also check best_sad/best_cand.
module tb_sad_block_controller;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 6;
  localparam int NCAND = 64;
  localparam int AW = 10;
  localparam int ALL1 = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sad_block_controller_if #(
    .DATA_W(DW), .BLOCK_LEN(BL), .CAND_W(CW)
  ) ifc ();

  sad_block_controller #(
    .DATA_W(DW), .BLOCK_LEN(BL), .CAND_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int q_sad[$];
  int q_cand[$];
  int m_cand = 0;
  int m_best = ALL1;
  int m_bcand = 0;
  int pa[BL];
  int pb[BL];

  task automatic chk(input string nm, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, int'(ifc.in_ready), 0);
    chk({tag, "_out_valid"}, int'(ifc.out_valid), 0);
    chk({tag, "_busy"}, int'(ifc.busy), 0);
    chk({tag, "_out_sad"}, int'(ifc.out_sad), 0);
    chk({tag, "_out_cand"}, int'(ifc.out_cand), 0);
`ifdef SAD_MIN_TRACK_EN
    chk({tag, "_best_sad"}, int'(ifc.best_sad), ALL1);
    chk({tag, "_best_cand"}, int'(ifc.best_cand), 0);
`endif
  endtask

  task automatic rand_pairs();
    for (int i = 0; i < BL; i++) begin
      pa[i] = int'($urandom_range(0, 255));
      pb[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic fill(input int a, input int b);
    for (int i = 0; i < BL; i++) begin
      pa[i] = a;
      pb[i] = b;
    end
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic run_block(input bit ns, input int gap,
                           input int rdy_wait);
    int sad = 0;
    int n = 0;
    int guard = 0;
    int lat = 0;
    bit took;
    for (int i = 0; i < BL; i++)
      sad += (pa[i] >= pb[i]) ? pa[i] - pb[i] : pb[i] - pa[i];
    chk("idle_busy", int'(ifc.busy), 0);
    chk("idle_in_ready", int'(ifc.in_ready), 0);
    ifc.start = 1'b1;
    ifc.new_search = ns;
    ifc.out_ready = (rdy_wait == 0);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.new_search = 1'b0;
    if (ns) begin
      m_cand = 0;
      m_best = ALL1;
      m_bcand = 0;
`ifdef SAD_MIN_TRACK_EN
      chk("best_cleared", int'(ifc.best_sad), ALL1);
`endif
    end
    q_sad.push_back(sad);
    q_cand.push_back(m_cand);
    while (n < BL && guard < 200) begin
      ifc.in_valid = int'($urandom_range(0, 99)) >= gap;
      ifc.in_a = DW'(pa[n]);
      ifc.in_b = DW'(pb[n]);
      took = ifc.in_valid && ifc.in_ready;
      @(negedge clk);
      if (took) n++;
      guard++;
    end
    chk("beats_accepted", n, BL);
    ifc.in_valid = 1'b1;
    chk("ready_after_last", int'(ifc.in_ready), 0);
    chk("busy_drain", int'(ifc.busy), 1);
    while (!ifc.out_valid && lat < 10) begin
      @(negedge clk);
      ifc.in_valid = 1'b0;
      lat++;
    end
    ifc.in_valid = 1'b0;
    chk("out_latency", lat, 2);
    for (int k = 0; k < rdy_wait; k++) begin
      ifc.start = (k == 1);
      ifc.new_search = (k == 1);
      chk("stall_valid", int'(ifc.out_valid), 1);
      chk("stall_busy", int'(ifc.busy), 1);
      chk("stall_sad", int'(ifc.out_sad), sad);
      chk("stall_cand", int'(ifc.out_cand), m_cand);
      @(negedge clk);
    end
    ifc.start = 1'b0;
    ifc.new_search = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    chk("single_pulse", int'(ifc.out_valid), 0);
    chk("idle_after_hs", int'(ifc.busy), 0);
    ifc.out_ready = 1'b0;
    if (sad < m_best) begin
      m_best = sad;
      m_bcand = m_cand;
    end
    m_cand = (m_cand + 1) % NCAND;
`ifdef SAD_MIN_TRACK_EN
    chk("best_sad", int'(ifc.best_sad), m_best);
    chk("best_cand", int'(ifc.best_cand), m_bcand);
`endif
  endtask

  // Scoreboard monitor: compares every result handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (ifc.out_valid && ifc.out_ready) begin
        if (q_sad.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: sad %0d cand %0d",
                   ifc.out_sad, ifc.out_cand);
        end else begin
          chk("out_sad", int'(ifc.out_sad), q_sad.pop_front());
          chk("out_cand", int'(ifc.out_cand),
              q_cand.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: time %0t, limit 1000000", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    ifc.start = 1'b0;
    ifc.new_search = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_a = '0;
    ifc.in_b = '0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    pa = '{10, 3, 255, 0};
    pb = '{3, 10, 0, 0};
    run_block(1'b1, 0, 0);

    fill(255, 0);
    run_block(1'b0, 40, 0);

    rand_pairs();
    run_block(1'b0, 20, 5);

    rand_pairs();
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_a = DW'(pa[0]);
    ifc.in_b = DW'(pb[0]);
    repeat (2) @(negedge clk);
    chk("midblock_busy", int'(ifc.busy), 1);
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    #1;
    chk_reset("midblock");
    @(negedge clk);
    rst = 1'b0;
    m_cand = 0;
    m_best = ALL1;
    m_bcand = 0;
    @(negedge clk);
    fill(1, 1);
    run_block(1'b0, 0, 0);

    fill(75, 0);
    run_block(1'b1, 0, 0);
    fill(0, 30);
    run_block(1'b0, 30, 1);
    run_block(1'b0, 0, 2);

    for (int b = 0; b < NCAND; b++) begin
      rand_pairs();
      run_block(1'b0, int'($urandom_range(0, 40)),
                int'($urandom_range(0, 2)));
    end
    rand_pairs();
    run_block(1'b1, 25, 0);
    for (int b = 0; b < 3; b++) begin
      rand_pairs();
      run_block(1'b0, 25, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q_sad.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
